// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS-subset controller:
// FSM states, instruction classes, ALU op codes and field encodings.
package multicycle_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_SLT = 4'h7
  } alu_op_e;

  typedef enum logic [3:0] {
    C_NOP, C_RTYPE, C_ADDI, C_LW, C_SW,
    C_BEQ, C_BNE, C_J, C_JR, C_SYSCALL
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_SYS   = 6'h0C;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

endpackage

// File: rtl/multicycle_ctrl_decoder.sv
// Combinational decode of opcode/funct into an
// instruction class and ALU operation.
module multicycle_ctrl_decoder
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_e    cls,
  output alu_op_e    alu_op
);

  logic rt;

  assign rt = (op == OP_RTYPE);

  // Anything not matched falls through as a NOP.
  always_comb begin
    cls    = C_NOP;
    alu_op = ALU_ADD;
    unique case (1'b1)
      rt && funct == FN_ADD: begin
        cls    = C_RTYPE;
        alu_op = ALU_ADD;
      end
      rt && funct == FN_SUB: begin
        cls    = C_RTYPE;
        alu_op = ALU_SUB;
      end
      rt && funct == FN_AND: begin
        cls    = C_RTYPE;
        alu_op = ALU_AND;
      end
      rt && funct == FN_OR: begin
        cls    = C_RTYPE;
        alu_op = ALU_OR;
      end
      rt && funct == FN_SLT: begin
        cls    = C_RTYPE;
        alu_op = ALU_SLT;
      end
      rt && funct == FN_JR:  cls = C_JR;
      rt && funct == FN_SYS: cls = C_SYSCALL;
      op == OP_ADDI:         cls = C_ADDI;
      op == OP_LW:           cls = C_LW;
      op == OP_SW:           cls = C_SW;
      op == OP_J:            cls = C_J;
      op == OP_BEQ: begin
        cls    = C_BEQ;
        alu_op = ALU_SUB;
      end
      op == OP_BNE: begin
        cls    = C_BNE;
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing controller: IF/ID/EX/MEM/WB FSM,
// instruction register, memory wait timeout and retire count.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int XLEN        = WORD_W,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             mem_read,
  output logic             mem_write,
  output logic             inst_fetch,
  output logic [XLEN-1:0]  ir,
  output logic             regDest,
  output logic             aluSrc,
  output logic [3:0]       alu_operation,
  output logic             memOrReg,
  output logic             reg_write_enable,
  output logic             branch,
  output logic             jump,
  output logic             jump_register,
  output logic             pc_we,
  output logic             halted,
  output logic             mem_error,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'(MEM_TIMEOUT - 1);

  state_e        state, nxt;
  iclass_e       cls;
  alu_op_e       dec_alu, alu_s;
  logic [TW-1:0] cnt;
  logic          timeout, load_ir, retire, err;
  logic          rd_s, src_s, m2r_s, rwe_s;
  logic          mr_s, mw_s, if_s;
  logic          br_s, j_s, jr_s, pc_s;

  multicycle_ctrl_decoder u_dec (
    .op     (ir[31:26]),
    .funct  (ir[5:0]),
    .cls    (cls),
    .alu_op (dec_alu)
  );

  assign timeout = (cnt == TO_LAST) && !mem_ready;

  always_comb begin
    nxt     = state;
    load_ir = 1'b0;
    err     = 1'b0;
    mr_s    = 1'b0;
    mw_s    = 1'b0;
    if_s    = 1'b0;
    rd_s    = 1'b0;
    src_s   = 1'b0;
    m2r_s   = 1'b0;
    rwe_s   = 1'b0;
    br_s    = 1'b0;
    j_s     = 1'b0;
    jr_s    = 1'b0;
    pc_s    = 1'b0;
    alu_s   = ALU_AND;
    // ALU controls stay put from EX through WB.
    if (state == S_EX || state == S_MEM ||
        state == S_WB) begin
      alu_s = dec_alu;
      src_s = (cls == C_ADDI) || (cls == C_LW) ||
              (cls == C_SW);
    end
    unique case (state)
      S_IF: begin
        mr_s = 1'b1;
        if_s = 1'b1;
        if (mem_ready) begin
          load_ir = 1'b1;
          nxt     = S_ID;
        end else if (timeout) begin
          err = 1'b1;
          nxt = S_HALT;
        end
      end
      S_ID: begin
        nxt = (cls == C_SYSCALL) ? S_HALT : S_EX;
      end
      S_EX: begin
        unique case (cls)
          C_LW, C_SW:      nxt = S_MEM;
          C_RTYPE, C_ADDI: nxt = S_WB;
          default: begin
            br_s = (cls == C_BEQ && zero) ||
                   (cls == C_BNE && !zero);
            j_s  = (cls == C_J);
            jr_s = (cls == C_JR);
            pc_s = 1'b1;
            nxt  = S_IF;
          end
        endcase
      end
      S_MEM: begin
        mr_s = (cls == C_LW);
        mw_s = (cls == C_SW);
        if (mem_ready) begin
          if (cls == C_LW) begin
            nxt = S_WB;
          end else begin
            pc_s = 1'b1;
            nxt  = S_IF;
          end
        end else if (timeout) begin
          err = 1'b1;
          nxt = S_HALT;
        end
      end
      S_WB: begin
        rwe_s = 1'b1;
        pc_s  = 1'b1;
        rd_s  = (cls == C_RTYPE);
        m2r_s = (cls == C_LW);
        nxt   = S_IF;
      end
      S_HALT: ;
      default: nxt = S_IF;
    endcase
  end

  assign retire = pc_s ||
    (state == S_ID && cls == C_SYSCALL);

  // Strobes are forced low while reset is held.
  assign mem_read         = mr_s  & rst_b;
  assign mem_write        = mw_s  & rst_b;
  assign inst_fetch       = if_s  & rst_b;
  assign regDest          = rd_s  & rst_b;
  assign aluSrc           = src_s & rst_b;
  assign memOrReg         = m2r_s & rst_b;
  assign reg_write_enable = rwe_s & rst_b;
  assign branch           = br_s  & rst_b;
  assign jump             = j_s   & rst_b;
  assign jump_register    = jr_s  & rst_b;
  assign pc_we            = pc_s  & rst_b;
  assign alu_operation    = rst_b ? alu_s : 4'h0;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state     <= S_IF;
      ir        <= '0;
      retired   <= '0;
      halted    <= 1'b0;
      mem_error <= 1'b0;
      cnt       <= '0;
    end else begin
      state <= nxt;
      if (load_ir) ir <= mem_rdata;
      if (retire) retired <= retired + CNT_W'(1);
      if (nxt == S_HALT) halted <= 1'b1;
      if (err) mem_error <= 1'b1;
      if ((state == S_IF || state == S_MEM) &&
          nxt == state && !mem_ready)
        cnt <= cnt + TW'(1);
      else
        cnt <= '0;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with
// hand-computed strobe patterns per cycle.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_b, mem_ready, zero;
  logic [31:0] mem_rdata;
  logic        mem_read, mem_write, inst_fetch;
  logic [31:0] ir;
  logic        regDest, aluSrc, memOrReg;
  logic [3:0]  alu_operation;
  logic        reg_write_enable, branch, jump;
  logic        jump_register, pc_we;
  logic        halted, mem_error;
  logic [31:0] retired;

  int errs = 0;
  int checks = 0;
  int exp_ret = 0;

  // {mr,mw,if}_{rd,src,m2r,rwe}_{br,j,jr,pc}
  logic [10:0] st;
  assign st = {mem_read, mem_write, inst_fetch,
               regDest, aluSrc, memOrReg,
               reg_write_enable, branch, jump,
               jump_register, pc_we};

  localparam logic [10:0] ST_IF = 11'b101_0000_0000;
  localparam logic [10:0] ST_0  = 11'b000_0000_0000;

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_ADDI = 32'h2021_0005;
  localparam logic [31:0] I_LW   = 32'h8C24_0008;
  localparam logic [31:0] I_SW   = 32'hAC22_0004;
  localparam logic [31:0] I_SYS  = 32'h0000_000C;
  localparam logic [31:0] I_NOP  = 32'h0000_0000;

  localparam logic [31:0] BR_INS [6] = '{
    32'h1022_0003, 32'h1022_0003, 32'h1422_0003,
    32'h0800_0010, 32'h03E0_0008, 32'h0000_0000};
  localparam logic BR_Z [6] = '{1, 0, 0, 0, 0, 0};
  localparam logic [10:0] BR_ST [6] = '{
    11'b000_0000_1001, 11'b000_0000_0001,
    11'b000_0000_1001, 11'b000_0000_0101,
    11'b000_0000_0011, 11'b000_0000_0001};
  localparam logic [3:0] BR_ALU [6] = '{
    4'h6, 4'h6, 4'h6, 4'h2, 4'h2, 4'h2};

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .mem_rdata        (mem_rdata),
    .mem_ready        (mem_ready),
    .zero             (zero),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .inst_fetch       (inst_fetch),
    .ir               (ir),
    .regDest          (regDest),
    .aluSrc           (aluSrc),
    .alu_operation    (alu_operation),
    .memOrReg         (memOrReg),
    .reg_write_enable (reg_write_enable),
    .branch           (branch),
    .jump             (jump),
    .jump_register    (jump_register),
    .pc_we            (pc_we),
    .halted           (halted),
    .mem_error        (mem_error),
    .retired          (retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_b = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    rst_b = 1'b1;
    #1;
    exp_ret = 0;
  endtask

  task automatic test_reset;
    rst_b = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    mem_rdata = '0;
    tick();
    #1;
    checks++;
    if ({st, alu_operation} !== 15'h0) begin
      errs++;
      $display("FAIL rst_hold st got %b want 0", st);
    end
    tick();
    rst_b = 1'b1;
    #1;
    checks++;
    if (st !== ST_IF) begin
      errs++;
      $display("FAIL rst_if st got %b want %b",
               st, ST_IF);
    end
    checks++;
    if ({ir, retired, halted, mem_error} !== 66'h0) begin
      errs++;
      $display("FAIL rst_regs ir=%h ret=%0d h=%b e=%b",
               ir, retired, halted, mem_error);
    end
  endtask

  task automatic test_reset_mid_sw;
    mem_ready = 1'b1;
    mem_rdata = I_SW;
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    checks++;
    if (st !== 11'b000_0100_0000) begin
      errs++;
      $display("FAIL sw_ex st got %b", st);
    end
    tick();
    #1;
    checks++;
    if (st !== 11'b010_0100_0000) begin
      errs++;
      $display("FAIL sw_mem st got %b want %b",
               st, 11'b010_0100_0000);
    end
    tick();
    rst_b = 1'b0;
    #1;
    checks++;
    if (st !== ST_0) begin
      errs++;
      $display("FAIL sw_rst st got %b want 0", st);
    end
    tick();
    rst_b = 1'b1;
    #1;
    checks++;
    if (st !== ST_IF || retired !== 32'd0) begin
      errs++;
      $display("FAIL sw_abort st=%b ret=%0d want %b 0",
               st, retired, ST_IF);
    end
    exp_ret = 0;
  endtask

  task automatic test_add;
    mem_ready = 1'b1;
    mem_rdata = I_ADD;
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (st !== ST_0 || ir !== I_ADD) begin
      errs++;
      $display("FAIL add_id st=%b ir=%h", st, ir);
    end
    tick();
    #1;
    checks++;
    if (st !== ST_0 || alu_operation !== 4'h2) begin
      errs++;
      $display("FAIL add_ex st=%b alu=%h want 0 2",
               st, alu_operation);
    end
    tick();
    #1;
    checks++;
    if (st !== 11'b000_1001_0001 ||
        alu_operation !== 4'h2) begin
      errs++;
      $display("FAIL add_wb st=%b alu=%h", st,
               alu_operation);
    end
    exp_ret++;
    tick();
    #1;
    checks++;
    if (st !== ST_IF || retired !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL add_ret st=%b ret=%0d want %0d",
               st, retired, exp_ret);
    end
  endtask

  task automatic test_lw_wait;
    mem_ready = 1'b1;
    mem_rdata = I_LW;
    tick();
    mem_ready = 1'b0;
    tick();
    #1;
    checks++;
    if (st !== 11'b000_0100_0000 ||
        alu_operation !== 4'h2) begin
      errs++;
      $display("FAIL lw_ex st=%b alu=%h", st,
               alu_operation);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++;
      if (st !== 11'b100_0100_0000) begin
        errs++;
        $display("FAIL lw_wait%0d st got %b", i, st);
      end
    end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (st !== 11'b100_0100_0000) begin
      errs++;
      $display("FAIL lw_rdy st got %b", st);
    end
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (st !== 11'b000_0111_0001) begin
      errs++;
      $display("FAIL lw_wb8 st got %b want %b",
               st, 11'b000_0111_0001);
    end
    exp_ret++;
    tick();
    #1;
    checks++;
    if (st !== ST_IF || retired !== 32'(exp_ret)) begin
      errs++;
      $display("FAIL lw_ret st=%b ret=%0d want %0d",
               st, retired, exp_ret);
    end
  endtask

  task automatic test_branch;
    for (int k = 0; k < 6; k++) begin
      mem_ready = 1'b1;
      mem_rdata = BR_INS[k];
      zero = BR_Z[k];
      tick();
      mem_ready = 1'b0;
      tick();
      #1;
      checks++;
      if (st !== BR_ST[k] ||
          alu_operation !== BR_ALU[k]) begin
        errs++;
        $display("FAIL br%0d_ex st=%b alu=%h want %b %h",
                 k, st, alu_operation, BR_ST[k],
                 BR_ALU[k]);
      end
      exp_ret++;
      tick();
      #1;
      checks++;
      if (st !== ST_IF || retired !== 32'(exp_ret)) begin
        errs++;
        $display("FAIL br%0d_ret st=%b ret=%0d want %0d",
                 k, st, retired, exp_ret);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_timeout;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st !== ST_IF || halted !== 1'b0) begin
        errs++;
        $display("FAIL to_wait%0d st=%b h=%b", i, st,
                 halted);
      end
      tick();
    end
    checks++;
    if (halted !== 1'b0) begin
      errs++;
      $display("FAIL to_early halted got 1 want 0");
    end
    tick();
    checks++;
    if ({halted, mem_error} !== 2'b11 || st !== ST_0 ||
        retired !== 32'd0) begin
      errs++;
      $display("FAIL to_halt h=%b e=%b st=%b ret=%0d",
               halted, mem_error, st, retired);
    end
  endtask

  task automatic test_syscall;
    logic [31:0] prog [3];
    int lat [3];
    int c;
    logic seen;
    prog = '{I_ADD, I_ADDI, I_NOP};
    lat = '{4, 4, 3};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b1;
      mem_rdata = prog[k];
      c = 1;
      seen = pc_we;
      while (!seen && c < 10) begin
        tick();
        c++;
        seen = pc_we;
      end
      checks++;
      if (!seen || c !== lat[k]) begin
        errs++;
        $display("FAIL sys_run%0d lat got %0d want %0d",
                 k, c, lat[k]);
      end
      tick();
    end
    mem_rdata = I_SYS;
    tick();
    #1;
    checks++;
    if (halted !== 1'b0 || st !== ST_0) begin
      errs++;
      $display("FAIL sys_id h=%b st=%b", halted, st);
    end
    tick();
    checks++;
    if ({halted, mem_error} !== 2'b10 ||
        retired !== 32'd4 || st !== ST_0) begin
      errs++;
      $display("FAIL sys_halt h=%b e=%b ret=%0d st=%b",
               halted, mem_error, retired, st);
    end
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'($urandom);
      zero = 1'($urandom);
      mem_rdata = $urandom;
      tick();
      #1;
      checks++;
      if (st !== ST_0 || alu_operation !== 4'h0 ||
          ir !== I_SYS || retired !== 32'd4 ||
          halted !== 1'b1 || mem_error !== 1'b0) begin
        errs++;
        $display("FAIL sys_frz%0d st=%b ir=%h ret=%0d",
                 i, st, ir, retired);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_sw();
    test_add();
    test_lw_wait();
    test_branch();
    test_timeout();
    test_syscall();
    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end

endmodule
